// File: rtl/hsv_core_alu_issue_arb.sv
// Round-robin issue arbiter feeding the shared two-stage ALU pipeline,
// with credit-based flow control toward the commit skid buffer and a flush sequencer.
// Ports: clk_core/rst_core_n; req_valid/req_ready/req_data per requester;
//   alu_valid/alu_ready/alu_data/alu_src to the ALU; retire from commit;
//   flush_req/flush_ack core flush handshake; alu_flush_req to ALU; credits (debug).
module hsv_core_alu_issue_arb #(
   parameter  int NUM_REQ      = 2,
   parameter  int WIDTH        = 64,
   parameter  int CREDITS      = 4,
   parameter  int FLUSH_CYCLES = 3,
   localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW = $clog2(CREDITS + 1),
   localparam int FW = $clog2(FLUSH_CYCLES + 1)
) (
   input  logic                     clk_core,
   input  logic                     rst_core_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic                     alu_valid,
   input  logic                     alu_ready,
   output logic [WIDTH-1:0]         alu_data,
   output logic [SW-1:0]            alu_src,
   input  logic                     retire,
   input  logic                     flush_req,
   output logic                     flush_ack,
   output logic                     alu_flush_req,
   output logic [CW-1:0]            credits
);

   typedef enum logic [1:0] {RUN, FLUSH, ACK, HOLD} state_t;

   state_t            state;
   state_t            state_next;
   logic [SW-1:0]     rr_ptr;
   logic [FW-1:0]     flush_cnt;
   logic              found;
   logic [SW-1:0]     grant;
   logic [SW-1:0]     ptr_next;
   logic [NUM_REQ-1:0] grant_oh;
   logic [WIDTH-1:0]  grant_data;
   logic              accept;
   logic              ret_ok;

   // Scan offsets 0..NUM_REQ-1 from rr_ptr; the first valid requester wins.
   always_comb begin
      found      = 1'b0;
      grant      = '0;
      ptr_next   = rr_ptr;
      grant_oh   = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_valid[j] &&
                j == ((int'(rr_ptr) + i) % NUM_REQ)) begin
               found       = 1'b1;
               grant       = SW'(j);
               ptr_next    = SW'((j + 1) % NUM_REQ);
               grant_oh[j] = 1'b1;
               grant_data  = req_data[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign accept = (state == RUN) && !flush_req && (credits != '0) &&
                   (!alu_valid || alu_ready) && found;

   assign req_ready = accept ? grant_oh : '0;

   // A retire with every credit already free cannot be real; drop it.
   assign ret_ok = retire && (credits != CW'(CREDITS));

   always_comb begin
      state_next    = state;
      alu_flush_req = 1'b0;
      flush_ack     = 1'b0;
      unique case (state)
         RUN:   if (flush_req) state_next = FLUSH;
         FLUSH: begin
            alu_flush_req = 1'b1;
            if (flush_cnt == FW'(FLUSH_CYCLES - 1)) state_next = ACK;
         end
         ACK: begin
            flush_ack  = 1'b1;
            state_next = flush_req ? HOLD : RUN;
         end
         HOLD:  if (!flush_req) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == FLUSH && state_next == FLUSH)
            flush_cnt <= flush_cnt + FW'(1);
         else
            flush_cnt <= '0;
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         alu_valid <= 1'b0;
         alu_data  <= '0;
         alu_src   <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         alu_valid <= 1'b1;
         alu_data  <= grant_data;
         alu_src   <= grant;
         rr_ptr    <= ptr_next;
      end else if (state == RUN && flush_req) begin
         alu_valid <= 1'b0;
      end else if (alu_valid && alu_ready) begin
         alu_valid <= 1'b0;
      end
   end

   // The flushed pipeline holds nothing, so ACK restores the full pool.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         credits <= CW'(CREDITS);
      end else begin
         unique case (state)
            ACK:     credits <= CW'(CREDITS);
            FLUSH:   credits <= credits;
            default: credits <= credits - CW'(accept) + CW'(ret_ok);
         endcase
      end
   end

   a_retire_legal: assert property (
      @(posedge clk_core) disable iff (!rst_core_n)
      !(retire && credits == CW'(CREDITS) &&
        (state == RUN || state == HOLD)));

endmodule

// File: tb/tb_hsv_core_alu_issue_arb.sv
// Bench for hsv_core_alu_issue_arb: table vectors, directed corner
// sequences and randomized traffic against a spec-level model.
module tb_hsv_core_alu_issue_arb;

   localparam int N  = 2;
   localparam int W  = 64;
   localparam int CR = 4;
   localparam int FC = 3;

   logic           clk_core = 1'b0;
   logic           rst_core_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data = '0;
   logic           alu_valid;
   logic           alu_ready = 1'b0;
   logic [W-1:0]   alu_data;
   logic           alu_src;
   logic           retire = 1'b0;
   logic           flush_req = 1'b0;
   logic           flush_ack;
   logic           alu_flush_req;
   logic [2:0]     credits;

   hsv_core_alu_issue_arb #(
      .NUM_REQ(N), .WIDTH(W), .CREDITS(CR), .FLUSH_CYCLES(FC)
   ) dut (
      .clk_core(clk_core), .rst_core_n(rst_core_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data),
      .alu_src(alu_src), .retire(retire), .flush_req(flush_req),
      .flush_ack(flush_ack), .alu_flush_req(alu_flush_req),
      .credits(credits)
   );

   always #5 clk_core = ~clk_core;

   int errors = 0;
   int checks = 0;

   // Reference model state (phase: 0 run, 1 flush, 2 ack, 3 hold)
   logic        m_valid;
   logic [63:0] m_data;
   int          m_src, m_credits, m_ptr, m_phase, m_fcnt;

   logic        last_acc, last_hs;
   int          last_src;
   logic [1:0]  dut_ready;
   logic        dut_fl, dut_ack;

   typedef struct {
      logic [1:0] rv;
      logic       fl;
      logic [1:0] exp_ready;
      logic       exp_valid;
      logic       exp_src;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_src = 0; m_credits = CR;
      m_ptr = 0; m_phase = 0; m_fcnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_core);
      rst_core_n = 1'b0;
      req_valid = '0; alu_ready = 1'b0; retire = 1'b0; flush_req = 1'b0;
      repeat (2) @(posedge clk_core);
      @(negedge clk_core);
      rst_core_n = 1'b1;
      model_reset();
   endtask

   task automatic step(input logic [1:0] rv, input logic ar, input logic rt,
                       input logic fl, input logic [127:0] rd);
      int g;
      logic acc;
      logic [1:0] er;
      @(negedge clk_core);
      req_valid = rv; alu_ready = ar; retire = rt; flush_req = fl;
      req_data = rd;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (g < 0 && ((rv >> idx) & 2'b01) != 0) g = idx;
      end
      acc = (m_phase == 0) && !fl && (m_credits != 0) &&
            (!m_valid || ar) && (g >= 0);
      er = acc ? 2'(1 << g) : 2'b00;
      dut_ready = req_ready; dut_fl = alu_flush_req; dut_ack = flush_ack;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("alu_valid", 64'(alu_valid), 64'(m_valid));
      chk("alu_src", 64'(alu_src), 64'(m_src));
      chk("alu_data", alu_data, m_data);
      chk("credits", 64'(credits), 64'(m_credits));
      chk("alu_flush_req", 64'(alu_flush_req), 64'(m_phase == 1));
      chk("flush_ack", 64'(flush_ack), 64'(m_phase == 2));
      last_acc = acc; last_hs = m_valid && ar; last_src = m_src;
      // credits
      if (m_phase == 2) m_credits = CR;
      else if (m_phase != 1)
         m_credits = m_credits - int'(acc) + int'(rt && m_credits < CR);
      // issue register
      if (acc) begin
         m_valid = 1'b1; m_src = g; m_data = 64'(rd >> (g * W));
         m_ptr = (g + 1) % N;
      end else if (m_phase == 0 && fl) m_valid = 1'b0;
      else if (m_valid && ar) m_valid = 1'b0;
      // flush sequencing
      case (m_phase)
         0: if (fl) begin m_phase = 1; m_fcnt = 0; end
         1: begin
            m_fcnt++;
            if (m_fcnt == FC) m_phase = 2;
         end
         2: m_phase = fl ? 3 : 0;
         default: if (!fl) m_phase = 0;
      endcase
   endtask

   initial begin
      int cnt, cnt2, cnt3, fl_left;
      logic [1:0] hist;
      logic have_prev;
      int prev_src;
      logic rt;

      model_reset();
      tbl[0] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      tbl[1] = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[2] = '{2'b10, 1'b0, 2'b10, 1'b1, 1'b1};
      tbl[3] = '{2'b11, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[4] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0};

      // Table vectors from reset
      for (int i = 0; i < 5; i++) begin
         do_reset();
         step(tbl[i].rv, 1'b1, 1'b0, tbl[i].fl, rnd_data());
         chk("tbl_ready", 64'(dut_ready), 64'(tbl[i].exp_ready));
         @(posedge clk_core); #1;
         chk("tbl_valid", 64'(alu_valid), 64'(tbl[i].exp_valid));
         if (tbl[i].exp_valid)
            chk("tbl_src", 64'(alu_src), 64'(tbl[i].exp_src));
      end

      // Round-robin stream, retire two cycles after each handshake
      do_reset();
      hist = 2'b00; have_prev = 1'b0; prev_src = 0;
      for (int i = 0; i < 14; i++) begin
         step(2'b11, 1'b1, hist[1], 1'b0, rnd_data());
         chk("no_stall", 64'(dut_ready != 2'b00), 64'(1));
         if (last_hs) begin
            if (have_prev)
               chk("alternate", 64'(last_src), 64'(prev_src == 0 ? 1 : 0));
            have_prev = 1'b1; prev_src = last_src;
         end
         hist = {hist[0], last_hs};
      end

      // Asynchronous reset mid-stream with alu_valid high
      @(negedge clk_core);
      chk("pre_rst_valid", 64'(alu_valid), 64'(m_valid));
      req_valid = '0; retire = 1'b0;
      #2 rst_core_n = 1'b0;
      #1;
      chk("rst_valid", 64'(alu_valid), 64'(0));
      chk("rst_credits", 64'(credits), 64'(CR));
      chk("rst_data", alu_data, 64'(0));
      chk("rst_src", 64'(alu_src), 64'(0));
      chk("rst_fl", 64'(alu_flush_req), 64'(0));
      chk("rst_ack", 64'(flush_ack), 64'(0));
      do_reset();

      // Backpressure holds the issue register
      step(2'b01, 1'b1, 1'b0, 1'b0, {rnd_data() >> 64, 64'hA5});
      for (int i = 0; i < 5; i++) begin
         step(2'b11, 1'b0, 1'b0, 1'b0, rnd_data());
         chk("bp_data", alu_data, 64'hA5);
         chk("bp_src", 64'(alu_src), 64'(0));
         chk("bp_ready", 64'(dut_ready), 64'(0));
      end
      step(2'b00, 1'b1, 1'b0, 1'b0, rnd_data());

      // Credit exhaustion and single-retire refill
      do_reset();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(2'b11, 1'b1, 1'b0, 1'b0, rnd_data());
         if (dut_ready != 2'b00) cnt++;
      end
      chk("credit_accepts", 64'(cnt), 64'(CR));
      cnt = 0;
      step(2'b11, 1'b1, 1'b1, 1'b0, rnd_data());
      if (dut_ready != 2'b00) cnt++;
      chk("no_bypass", 64'(cnt), 64'(0));
      for (int i = 0; i < 5; i++) begin
         step(2'b11, 1'b1, 1'b0, 1'b0, rnd_data());
         if (dut_ready != 2'b00) cnt++;
      end
      chk("refill_accepts", 64'(cnt), 64'(1));

      // Flush with three ops in flight, held into HOLD
      do_reset();
      for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 1'b0, rnd_data());
      cnt = 0; cnt2 = 0; cnt3 = 0;
      for (int i = 0; i < 8; i++) begin
         step(2'b11, 1'b1, 1'b0, 1'b1, rnd_data());
         if (dut_fl) cnt++;
         if (dut_ack) cnt2++;
         if (dut_ready != 2'b00) cnt3++;
      end
      chk("flush_cycles", 64'(cnt), 64'(FC));
      chk("flush_acks", 64'(cnt2), 64'(1));
      chk("flush_no_issue", 64'(cnt3), 64'(0));
      step(2'b00, 1'b1, 1'b0, 1'b0, rnd_data());
      step(2'b00, 1'b1, 1'b0, 1'b0, rnd_data());
      chk("flush_credits", 64'(credits), 64'(CR));

      // Randomized traffic against the model
      do_reset();
      fl_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (fl_left == 0 && $urandom_range(0, 59) == 0)
            fl_left = $urandom_range(1, 9);
         rt = (m_phase == 0) && (m_credits < CR) && ($urandom_range(0, 2) == 0);
         step(2'($urandom), ($urandom_range(0, 3) != 0), rt,
              (fl_left != 0), rnd_data());
         if (fl_left != 0) fl_left--;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
